// File: rtl/minbd_local_inject_queue.sv
// rtl/minbd_local_inject_queue.sv - local-injection FIFO with 2-cycle grant tracking and deny re-offer
//
// Buffers core flits and offers one per cycle to the router local input. The
// router answers each offer two cycles later on inj_gnt. Denied flits are
// re-offered ahead of FIFO traffic, so no flit is lost or duplicated.
//
// Flit layout (flit_ext_t): bit [WIDTH_FLIT_EXT-1] is vld, the lower bits are
// the payload carried through untouched.
//
// Ports:
//   clk       clock
//   n_rst     asynchronous active-low reset
//   enq_flit  flit from core; vld bit requests an enqueue
//   enq_rdy   FIFO can accept enq_flit this cycle
//   inj_flit  flit offered to router din_l; vld=1 means offer
//   inj_gnt   router accept/deny of the offer made two cycles earlier
//   count     FIFO occupancy, in-flight copies excluded
//   empty     FIFO and both in-flight stages empty
//   starve    consecutive-deny streak has reached STARVE_LIMIT
//   err_gnt   sticky: grant seen with no offer pending
module minbd_local_inject_queue #(
    parameter int DEPTH          = 8,
    parameter int STARVE_LIMIT   = 16,
    parameter int WIDTH_FLIT_EXT = 16,
    localparam int CW            = $clog2(DEPTH + 1),
    localparam int PW            = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic [WIDTH_FLIT_EXT-1:0] enq_flit,
    output logic                      enq_rdy,
    output logic [WIDTH_FLIT_EXT-1:0] inj_flit,
    input  logic                      inj_gnt,
    output logic [CW-1:0]             count,
    output logic                      empty,
    output logic                      starve,
    output logic                      err_gnt
);

    localparam int VLD = WIDTH_FLIT_EXT - 1;

    logic [WIDTH_FLIT_EXT-1:0] mem [DEPTH];
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic [CW-1:0]             count_q;
    logic [WIDTH_FLIT_EXT-1:0] d1;
    logic [WIDTH_FLIT_EXT-1:0] d2;
    logic [7:0]                deny_streak;
    logic                      err_q;

    logic deny;
    logic fifo_ne;
    logic push;
    logic pop;

    // enq_rdy depends only on registered count so there is no
    // combinational path from the router side back to the core.
    assign enq_rdy = (count_q != CW'(DEPTH));
    assign fifo_ne = (count_q != '0);
    assign deny    = d2[VLD] && !inj_gnt;
    assign push    = enq_flit[VLD] && enq_rdy;
    // A denied flit takes the offer slot, so the FIFO head waits.
    assign pop     = !deny && fifo_ne;

    always_comb begin
        inj_flit = '0;
        if (deny) begin
            inj_flit = d2;
        end else if (fifo_ne) begin
            inj_flit = mem[rd_ptr];
        end
    end

    // Storage has no reset; entries are only read when count says valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enq_flit;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            d1          <= '0;
            d2          <= '0;
            deny_streak <= '0;
            err_q       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

            // A granted d2 simply shifts out; a denied one has already been
            // copied into inj_flit and therefore lands back in d1.
            d1 <= inj_flit;
            d2 <= d1;

            if (d2[VLD]) begin
                if (inj_gnt) begin
                    deny_streak <= '0;
                end else if (deny_streak != 8'hFF) begin
                    deny_streak <= deny_streak + 8'd1;
                end
            end

            if (inj_gnt && !d2[VLD]) begin
                err_q <= 1'b1;
            end
        end
    end

    assign count   = count_q;
    assign empty   = !fifo_ne && !d1[VLD] && !d2[VLD];
    assign starve  = (deny_streak >= 8'(STARVE_LIMIT));
    assign err_gnt = err_q;

endmodule

// File: tb/tb_minbd_local_inject_queue.sv
// tb/tb_minbd_local_inject_queue.sv - scoreboard bench for minbd_local_inject_queue
module tb_minbd_local_inject_queue;

    localparam int DEPTH = 8;
    localparam int W     = 16;

    logic         clk;
    logic         n_rst;
    logic [W-1:0] enq_flit;
    logic         enq_rdy;
    logic [W-1:0] inj_flit;
    logic         inj_gnt;
    logic [3:0]   count;
    logic         empty;
    logic         starve;
    logic         err_gnt;

    minbd_local_inject_queue #(
        .DEPTH(DEPTH),
        .STARVE_LIMIT(16),
        .WIDTH_FLIT_EXT(W)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .enq_flit(enq_flit),
        .enq_rdy(enq_rdy),
        .inj_flit(inj_flit),
        .inj_gnt(inj_gnt),
        .count(count),
        .empty(empty),
        .starve(starve),
        .err_gnt(err_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [14:0] pend[$];
    logic [14:0] offers[$];
    int          grants;
    logic [W-1:0] h1, h2;
    int          mcount;
    int          mstreak;
    logic        merr;
    logic [14:0] base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mcount  = 0;
        mstreak = 0;
        merr    = 1'b0;
        h1      = '0;
        h2      = '0;
        pend.delete();
    endtask

    // gm: 0 = deny, 1 = grant whatever is pending in d2, 2 = force grant high
    task automatic tick(input logic ev, input logic [14:0] ep, input int gm);
        logic g, deny, grant, push, pop;
        logic [W-1:0] cur;
        int idx;
        g = (gm == 1) ? h2[15] : (gm == 2);
        enq_flit = {ev, ep};
        inj_gnt  = g;
        #2;
        deny  = h2[15] && !g;
        grant = h2[15] && g;
        cur   = inj_flit;
        check("inj_vld", 32'(cur[15]), 32'(deny || mcount > 0));
        if (deny) check("reoffer", 32'(cur), 32'(h2));
        if (!cur[15]) check("idle_zero", 32'(cur), 32'd0);
        check("enq_rdy", 32'(enq_rdy), 32'(mcount != DEPTH));
        check("count", 32'(count), 32'(mcount));
        check("empty", 32'(empty), 32'(mcount == 0 && !h1[15] && !h2[15]));
        check("starve", 32'(starve), 32'(mstreak >= 16));
        check("err_gnt", 32'(err_gnt), 32'(merr));
        if (grant) begin
            idx = -1;
            foreach (pend[i]) if (pend[i] == h2[14:0]) idx = i;
            check("grant_known", 32'(idx >= 0), 32'd1);
            if (idx >= 0) pend.delete(idx);
            grants++;
        end
        push = ev && (mcount != DEPTH);
        pop  = !deny && (mcount > 0);
        if (push) pend.push_back(ep);
        if (cur[15]) offers.push_back(cur[14:0]);
        mcount = mcount + int'(push) - int'(pop);
        if (grant) mstreak = 0;
        else if (deny && mstreak < 255) mstreak++;
        if (g && !h2[15]) merr = 1'b1;
        @(posedge clk);
        #1;
        h2 = h1;
        h1 = cur;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((mcount > 0 || h1[15] || h2[15]) && n < budget) begin
            tick(1'b0, 15'd0, 1);
            n++;
        end
        check("drain_bound", 32'(n < budget), 32'd1);
    endtask

    initial begin
        n_rst    = 1'b0;
        enq_flit = '0;
        inj_gnt  = 1'b0;
        grants   = 0;
        model_reset();
        #3;
        check("rst_inj", 32'(inj_flit), 32'd0);
        check("rst_rdy", 32'(enq_rdy), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // T2: 8 back-to-back, always grant
        base = 15'h100; offers.delete(); grants = 0;
        for (int i = 0; i < 8; i++) tick(1'b1, base + 15'(i), 1);
        drain(30);
        check("t2_grants", 32'(grants), 32'd8);
        check("t2_offers", 32'(offers.size()), 32'd8);
        for (int i = 0; i < 8 && i < offers.size(); i++)
            check("t2_order", 32'(offers[i]), 32'(base + 15'(i)));
        check("t2_empty", 32'(empty), 32'd1);
        check("t2_pend", 32'(pend.size()), 32'd0);

        // T3: A,B,C; A denied once; A re-offer pre-empts C
        base = 15'h200; offers.delete(); grants = 0;
        tick(1'b1, base, 1);
        tick(1'b1, base + 15'd1, 1);
        tick(1'b1, base + 15'd2, 1);
        tick(1'b0, 15'd0, 0);
        drain(20);
        check("t3_grants", 32'(grants), 32'd3);
        check("t3_offers", 32'(offers.size()), 32'd4);
        if (offers.size() == 4) begin
            check("t3_o0", 32'(offers[0]), 32'(base));
            check("t3_o1", 32'(offers[1]), 32'(base + 15'd1));
            check("t3_o2", 32'(offers[2]), 32'(base));
            check("t3_o3", 32'(offers[3]), 32'(base + 15'd2));
        end
        check("t3_pend", 32'(pend.size()), 32'd0);

        // T4: fill DEPTH+2 under continuous deny, one extra dropped
        base = 15'h300; grants = 0;
        for (int i = 0; i < 11; i++) tick(1'b1, base + 15'(i), 0);
        check("t4_count", 32'(count), 32'd8);
        check("t4_rdy", 32'(enq_rdy), 32'd0);
        check("t4_pend", 32'(pend.size()), 32'd10);
        drain(60);
        check("t4_grants", 32'(grants), 32'd10);
        check("t4_pend_done", 32'(pend.size()), 32'd0);

        // T5: starve after 16 consecutive denies
        base = 15'h400; grants = 0;
        tick(1'b1, base, 0);
        tick(1'b1, base + 15'd1, 0);
        for (int i = 0; i < 16; i++) tick(1'b0, 15'd0, 0);
        check("t5_starve15", 32'(starve), 32'd0);
        tick(1'b0, 15'd0, 0);
        check("t5_starve16", 32'(starve), 32'd1);
        drain(20);
        check("t5_starve_clr", 32'(starve), 32'd0);
        check("t5_grants", 32'(grants), 32'd2);

        // T6: spurious grant on empty queue
        tick(1'b0, 15'd0, 2);
        check("t6_err", 32'(err_gnt), 32'd1);
        check("t6_count", 32'(count), 32'd0);
        check("t6_empty", 32'(empty), 32'd1);
        tick(1'b0, 15'd0, 1);

        // T1: reset mid-traffic
        base = 15'h500;
        tick(1'b1, base, 1);
        tick(1'b1, base + 15'd1, 1);
        tick(1'b1, base + 15'd2, 1);
        n_rst = 1'b0;
        #1;
        check("t1_inj", 32'(inj_flit), 32'd0);
        check("t1_rdy", 32'(enq_rdy), 32'd1);
        check("t1_count", 32'(count), 32'd0);
        check("t1_empty", 32'(empty), 32'd1);
        check("t1_starve", 32'(starve), 32'd0);
        check("t1_err", 32'(err_gnt), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        grants = 0;
        tick(1'b0, 15'd0, 1);
        tick(1'b1, base + 15'd9, 1);
        drain(20);
        check("t1_grants", 32'(grants), 32'd1);
        check("t1_pend", 32'(pend.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
